audio_dac_tx: RTL and testbench

- Codec-side end of the sample/frame interface.
- Generates the frame request pulse (new_frame) that the sample producer synchronizes as its sampling pulse.
- Captures the 16-bit sample the producer supplies in response.
- Serializes that sample, MSB first, onto a left-justified stereo serial link (bclk, lrclk, sdata) toward the DAC.
- Mono source: the same sample is sent in both the left and right slots of a frame.

---
 rtl/audio_dac_tx.sv | 93 +++++++++
 tb/tb_audio_dac_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: codec-side frame requester and left-justified stereo serializer.
// One 16-bit mono sample is captured per frame and sent MSB first in both channel slots.
module audio_dac_tx #(
  parameter int DIV_HALF = 4,
  parameter int NF_SLOTS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] sample,
  output logic        new_frame,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic [7:0]  frame_cnt
);

  localparam int              PH_W    = $clog2(2 * DIV_HALF);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV_HALF - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIV_HALF);
  localparam logic [4:0]      NF_LIM  = 5'(NF_SLOTS);

  logic [PH_W-1:0]    phase;
  logic [4:0]         slot;
  logic signed [15:0] shadow;
  logic signed [15:0] shift;

  logic bit_start;
  logic phase_last;
  logic capture;
  logic chan_load;

  always_comb begin
    bit_start  = (phase == '0);
    phase_last = (phase == PH_LAST);
    capture    = bit_start && (slot == 5'd31);
    // Slots 0 and 16 both reload the shift register from the shadow copy.
    chan_load  = bit_start && (slot[3:0] == 4'd0);
  end

  // Bit-phase and slot counters; idle and reset both park them at frame start.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      phase <= '0;
      slot  <= '0;
    end else begin
      phase <= phase_last ? '0 : phase + PH_W'(1);
      if (phase_last)
        slot <= slot + 5'd1;
    end
  end

  // Capture ignores enable so a frame aborted in the capture cycle still latches the sample.
  always_ff @(posedge clk) begin
    if (reset)
      shadow <= '0;
    else if (capture)
      shadow <= sample;
  end

  // Registered link outputs, derived from the counter state of the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift     <= '0;
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      new_frame <= 1'b0;
      frame_cnt <= '0;
    end else if (!enable) begin
      bclk      <= 1'b0;
      lrclk     <= 1'b0;
      sdata     <= 1'b0;
      new_frame <= 1'b0;
    end else begin
      bclk      <= (phase >= PH_HALF);
      new_frame <= (slot < NF_LIM);
      if (bit_start) begin
        lrclk <= slot[4];
        if (chan_load) begin
          shift <= shadow;
          sdata <= shadow[15];
        end else begin
          shift <= shift << 1;
          sdata <= shift[14];
        end
        if (slot == 5'd0)
          frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Bench for audio_dac_tx: decodes the serial link and compares each frame's
// received left/right words against a queue of expected captured samples.
module tb_audio_dac_tx;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] sample;
  logic        nf1, bclk1, lr1, sd1;
  logic [7:0]  fc1;
  logic        nf3, bclk3, lr3, sd3;
  logic [7:0]  fc3;

  int          n_cmp;
  int          n_bad;
  logic [7:0]  exp_fc;
  logic [15:0] exp_q[$];
  logic [15:0] discard;

  audio_dac_tx #(.DIV_HALF(2), .NF_SLOTS(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .sample(sample),
    .new_frame(nf1), .bclk(bclk1), .lrclk(lr1), .sdata(sd1), .frame_cnt(fc1)
  );

  audio_dac_tx #(.DIV_HALF(2), .NF_SLOTS(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .sample(sample),
    .new_frame(nf3), .bclk(bclk3), .lrclk(lr3), .sdata(sd3), .frame_cnt(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Receive one full frame (128 clk cycles at DIV_HALF=2) starting at the next edge.
  task automatic rx_frame(input string tag, input int chg_at, input logic [15:0] chg_val);
    logic [15:0] l1, r1, l3, r3, expw;
    logic        s1, s3;
    int          terr, n1, n3, s, ph;
    l1 = '0; r1 = '0; l3 = '0; r3 = '0;
    s1 = 1'b0; s3 = 1'b0;
    terr = 0; n1 = 0; n3 = 0;
    exp_fc = exp_fc + 8'd1;
    for (int i = 0; i < 128; i++) begin
      cyc();
      s  = i / 4;
      ph = i % 4;
      if (i == 0)
        check($sformatf("%s_fc", tag), 32'({fc1, fc3}), 32'({exp_fc, exp_fc}));
      if (bclk1 !== (ph >= 2)) terr++;
      if (bclk3 !== (ph >= 2)) terr++;
      if (lr1 !== (s >= 16)) terr++;
      if (lr3 !== (s >= 16)) terr++;
      if (nf1 !== (s < 1)) terr++;
      if (nf3 !== (s < 3)) terr++;
      if (nf1 === 1'b1) n1++;
      if (nf3 === 1'b1) n3++;
      if (ph == 0) begin
        s1 = sd1;
        s3 = sd3;
      end else begin
        if (sd1 !== s1) terr++;
        if (sd3 !== s3) terr++;
      end
      if (ph == 2) begin
        if (s < 16) begin
          l1[4'(15 - s)] = sd1;
          l3[4'(15 - s)] = sd3;
        end else begin
          r1[4'(31 - s)] = sd1;
          r3[4'(31 - s)] = sd3;
        end
      end
      if (i == chg_at) sample = chg_val;
      if (i == 123) exp_q.push_back(sample);
    end
    expw = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    check($sformatf("%s_timing", tag), 32'(terr), 32'd0);
    check($sformatf("%s_nf_w1", tag), 32'(n1), 32'd4);
    check($sformatf("%s_nf_w3", tag), 32'(n3), 32'd12);
    check($sformatf("%s_data1", tag), {l1, r1}, {expw, expw});
    check($sformatf("%s_data3", tag), {l3, r3}, {expw, expw});
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    exp_fc = 8'd0;
    reset  = 1'b1;
    enable = 1'b0;
    sample = 16'h0000;

    // Reset for 3 cycles
    repeat (3) cyc();
    check("reset_outs", 32'({nf1, bclk1, lr1, sd1, fc1, nf3, bclk3, lr3, sd3, fc3}), 32'd0);
    exp_q.push_back(16'h0000);

    // Frame 0 sends the reset shadow; frame 1 sends the held sample
    reset  = 1'b0;
    enable = 1'b1;
    sample = 16'hA5C3;
    rx_frame("f0_zero", -1, 16'h0000);
    rx_frame("f1_a5c3", -1, 16'h0000);

    // Sample changes exactly on the capture edge, then one cycle later
    sample = 16'h0001;
    rx_frame("f2_chg_at", 123, 16'h8000);
    sample = 16'h0001;
    rx_frame("f3_chg_late", 124, 16'h8000);
    rx_frame("f4_0001", -1, 16'h0000);

    // Drop enable mid-slot 9 for 10 cycles
    exp_fc = exp_fc + 8'd1;
    for (int i = 0; i <= 38; i++) begin
      cyc();
      if (i == 0) check("f5_fc", 32'(fc1), 32'(exp_fc));
    end
    enable = 1'b0;
    sample = 16'h1234;
    cyc();
    check("drop_outs", 32'({nf1, bclk1, lr1, sd1, nf3, bclk3, lr3, sd3}), 32'd0);
    repeat (9) cyc();
    check("idle_outs", 32'({nf1, bclk1, lr1, sd1, nf3, bclk3, lr3, sd3}), 32'd0);
    check("idle_fc", 32'(fc1), 32'(exp_fc));
    enable = 1'b1;
    rx_frame("restart", -1, 16'h0000);

    // Reset during slot 20 with enable still high
    exp_fc = exp_fc + 8'd1;
    for (int i = 0; i <= 82; i++) begin
      cyc();
      if (i == 0) check("f7_fc", 32'(fc1), 32'(exp_fc));
    end
    reset = 1'b1;
    cyc();
    check("rst_mid_outs", 32'({nf1, bclk1, lr1, sd1, fc1, nf3, bclk3, lr3, sd3, fc3}), 32'd0);
    repeat (2) cyc();
    reset  = 1'b0;
    exp_fc = 8'd0;
    exp_q.delete();
    exp_q.push_back(16'h0000);
    rx_frame("post_rst", -1, 16'h0000);

    // 256 frames of varying samples; frame_cnt wraps 255->0
    for (int f = 0; f < 256; f++) begin
      sample = 16'($urandom);
      rx_frame($sformatf("run%0d", f), -1, 16'h0000);
    end

    // Enable falls in the capture cycle: capture still happens
    exp_fc = exp_fc + 8'd1;
    sample = 16'h5A5A;
    for (int i = 0; i <= 123; i++) begin
      cyc();
      if (i == 0) check("capfall_fc", 32'(fc1), 32'(exp_fc));
      if (i == 123) enable = 1'b0;
    end
    cyc();
    check("capfall_outs", 32'({nf1, bclk1, lr1, sd1, nf3, bclk3, lr3, sd3}), 32'd0);
    if (exp_q.size() > 0) discard = exp_q.pop_front();
    exp_q.push_back(16'h5A5A);
    sample = 16'h0F0F;
    repeat (3) cyc();
    enable = 1'b1;
    rx_frame("capfall_tx", -1, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
